// File: rtl/fetch_align_gen.sv
// Fetch-group address generator: aligns the fetch PC to an ISSUE_W-instruction group and marks the valid lanes.
// Optional accepted-partial-group counter enabled by defining FETCH_ALIGN_PERF_EN.
module fetch_align_gen #(
   parameter int unsigned ISSUE_W  = 4,
   parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [31:0]                group_pc,
   output logic [ISSUE_W-1:0]         lane_valid,
   output logic [$clog2(ISSUE_W)-1:0] first_lane,
   output logic                       adel,
   output logic [31:0]                partial_cnt
);

   localparam int unsigned GB = ISSUE_W * 4;
   localparam int unsigned OB = $clog2(GB);
   localparam int unsigned LW = $clog2(ISSUE_W);

   typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] grp_base;
   logic [LW-1:0] pc_lane;

   assign grp_base = pc_q & ~32'(GB - 1);
   assign pc_lane  = pc_q[OB-1:2];

   // State and fetch-address register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // Next state: redirect wins over accept and stall in every state
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (redirect) begin
         pc_d    = redirect_pc;
         state_d = (redirect_pc[1:0] != 2'b00) ? FAULT : RUN;
      end else begin
         case (state_q)
            BOOT:    state_d = RUN;
            RUN:     if (out_ready) pc_d = grp_base + 32'(GB);
            FAULT:   state_d = FAULT;
            default: state_d = BOOT;
         endcase
      end
   end

   // Outputs depend only on registered state
   always_comb begin
      out_valid  = 1'b0;
      group_pc   = '0;
      lane_valid = '0;
      first_lane = '0;
      adel       = 1'b0;
      case (state_q)
         RUN: begin
            out_valid  = 1'b1;
            group_pc   = grp_base;
            first_lane = pc_lane;
            for (int i = 0; i < int'(ISSUE_W); i++)
               lane_valid[i] = (LW'(i) >= pc_lane);
         end
         FAULT: begin
            out_valid = 1'b1;
            adel      = 1'b1;
            group_pc  = pc_q;
         end
         default: ;
      endcase
   end

`ifdef FETCH_ALIGN_PERF_EN
   logic [31:0] cnt_q;
   logic        part_acc;

   // An accept still counts when a redirect arrives in the same cycle
   assign part_acc = (state_q == RUN) && out_ready && (pc_lane != '0);

   always_ff @(posedge clk) begin
      if (reset)
         cnt_q <= '0;
      else if (part_acc && (cnt_q != 32'hFFFFFFFF))
         cnt_q <= cnt_q + 32'd1;
   end

   assign partial_cnt = cnt_q;
`else
   assign partial_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_align_gen.sv
// Directed bench for fetch_align_gen: vector table for ISSUE_W=4 plus hand sequences for reset and ISSUE_W=8.
module tb_fetch_align_gen;

`ifdef FETCH_ALIGN_PERF_EN
   localparam int unsigned PE = 1;
`else
   localparam int unsigned PE = 0;
`endif

   logic        clk = 1'b0;
   logic        reset, redirect, out_ready;
   logic [31:0] redirect_pc;

   logic        v4, adel4, v8, adel8;
   logic [31:0] gpc4, cnt4, gpc8, cnt8;
   logic [3:0]  lv4;
   logic [1:0]  fl4;
   logic [7:0]  lv8;
   logic [2:0]  fl8;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   fetch_align_gen #(.ISSUE_W(4)) dut4 (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .out_ready(out_ready), .out_valid(v4), .group_pc(gpc4), .lane_valid(lv4),
      .first_lane(fl4), .adel(adel4), .partial_cnt(cnt4));

   fetch_align_gen #(.ISSUE_W(8)) dut8 (
      .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
      .out_ready(out_ready), .out_valid(v8), .group_pc(gpc8), .lane_valid(lv8),
      .first_lane(fl8), .adel(adel8), .partial_cnt(cnt8));

   always #5 clk = ~clk;

   typedef struct {
      logic        rd;
      logic [31:0] rpc;
      logic        rdy;
      logic        ev;
      logic [31:0] egpc;
      logic [3:0]  elv;
      logic [1:0]  efl;
      logic        eadel;
      logic [31:0] ecnt;
   } vec_t;

   vec_t tv[20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic rd, input logic [31:0] rpc, input logic rdy);
      redirect    = rd;
      redirect_pc = rpc;
      out_ready   = rdy;
      @(posedge clk);
      #1;
   endtask

   task automatic chk4(input string tag, input logic ev, input logic [31:0] egpc,
                       input logic [3:0] elv, input logic [1:0] efl, input logic eadel,
                       input logic [31:0] ecnt);
      chk({tag, ".valid"}, 32'(v4), 32'(ev));
      chk({tag, ".group_pc"}, gpc4, egpc);
      chk({tag, ".lane_valid"}, 32'(lv4), 32'(elv));
      chk({tag, ".first_lane"}, 32'(fl4), 32'(efl));
      chk({tag, ".adel"}, 32'(adel4), 32'(eadel));
      chk({tag, ".partial_cnt"}, cnt4, ecnt);
   endtask

   initial begin
      // rd, rpc, rdy | valid, group_pc, lanes, first, adel, partial count
      tv[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00000, 4'b1111, 2'd0, 1'b0, 0};
      tv[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hBFC00010, 4'b1111, 2'd0, 1'b0, 0};
      tv[2]  = '{1'b1, 32'h00001008, 1'b0, 1'b1, 32'h00001000, 4'b1100, 2'd2, 1'b0, 0};
      tv[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h00001010, 4'b1111, 2'd0, 1'b0, PE};
      tv[4]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h00001010, 4'b1111, 2'd0, 1'b0, PE};
      tv[5]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h00001010, 4'b1111, 2'd0, 1'b0, PE};
      tv[6]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h00001010, 4'b1111, 2'd0, 1'b0, PE};
      tv[7]  = '{1'b1, 32'h00004000, 1'b1, 1'b1, 32'h00004000, 4'b1111, 2'd0, 1'b0, PE};
      tv[8]  = '{1'b1, 32'h00002002, 1'b0, 1'b1, 32'h00002002, 4'b0000, 2'd0, 1'b1, PE};
      for (int i = 9; i < 14; i++)
         tv[i] = '{1'b0, 32'h0,      1'b1, 1'b1, 32'h00002002, 4'b0000, 2'd0, 1'b1, PE};
      tv[14] = '{1'b1, 32'h00003000, 1'b0, 1'b1, 32'h00003000, 4'b1111, 2'd0, 1'b0, PE};
      tv[15] = '{1'b1, 32'hFFFFFFF4, 1'b1, 1'b1, 32'hFFFFFFF0, 4'b1110, 2'd1, 1'b0, PE};
      tv[16] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h00000000, 4'b1111, 2'd0, 1'b0, 2*PE};
      tv[17] = '{1'b1, 32'h00001008, 1'b1, 1'b1, 32'h00001000, 4'b1100, 2'd2, 1'b0, 2*PE};
      tv[18] = '{1'b1, 32'h00002000, 1'b1, 1'b1, 32'h00002000, 4'b1111, 2'd0, 1'b0, 3*PE};
      tv[19] = '{1'b1, 32'h00000001, 1'b0, 1'b1, 32'h00000001, 4'b0000, 2'd0, 1'b1, 3*PE};

      // Reset held with redirect/ready active must still give BOOT values
      reset = 1'b1;
      drive(1'b1, 32'h00005000, 1'b1);
      drive(1'b1, 32'h00005000, 1'b1);
      chk4("reset", 1'b0, 32'h0, 4'b0000, 2'd0, 1'b0, 32'h0);

      // Single BOOT cycle after release, even with out_ready high
      reset = 1'b0;
      redirect = 1'b0;
      out_ready = 1'b1;
      #1;
      chk("boot.valid", 32'(v4), 32'h0);

      for (int i = 0; i < 20; i++) begin
         drive(tv[i].rd, tv[i].rpc, tv[i].rdy);
         chk4($sformatf("vec%0d", i), tv[i].ev, tv[i].egpc, tv[i].elv, tv[i].efl,
              tv[i].eadel, tv[i].ecnt);
      end

      // Mid-stream reset discards the pending group and the counter
      reset = 1'b1;
      drive(1'b1, 32'h00007000, 1'b1);
      chk4("midrst", 1'b0, 32'h0, 4'b0000, 2'd0, 1'b0, 32'h0);
      chk("midrst.valid8", 32'(v8), 32'h0);
      chk("midrst.cnt8", cnt8, 32'h0);

      // Redirect straight out of BOOT
      reset = 1'b0;
      drive(1'b1, 32'h0000500C, 1'b0);
      chk4("bootrd", 1'b1, 32'h00005000, 4'b1000, 2'd3, 1'b0, 32'h0);

      // Wider group: same address lands in different lanes
      drive(1'b1, 32'h00001018, 1'b0);
      chk4("w4", 1'b1, 32'h00001010, 4'b1100, 2'd2, 1'b0, 32'h0);
      chk("w8.group_pc", gpc8, 32'h00001000);
      chk("w8.lane_valid", 32'(lv8), 32'h000000C0);
      chk("w8.first_lane", 32'(fl8), 32'd6);
      chk("w8.adel", 32'(adel8), 32'h0);

      drive(1'b0, 32'h0, 1'b1);
      chk4("w4acc", 1'b1, 32'h00001020, 4'b1111, 2'd0, 1'b0, PE);
      chk("w8acc.group_pc", gpc8, 32'h00001020);
      chk("w8acc.lane_valid", 32'(lv8), 32'h000000FF);
      chk("w8acc.partial_cnt", cnt8, PE);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
